// File: rtl/btb_pkg.sv
// Shared types and constants for the set-associative branch target buffer.
package btb_pkg;

    localparam int ADDR_W      = 32;
    localparam int SETS_DEF    = 512;
    localparam int WAYS_DEF    = 2;
    localparam int CTR_W_DEF   = 2;

    // Counter field is sized for the widest supported counter; narrower
    // configurations keep the unused upper bits at zero.
    localparam int CTR_FIELD_W = 3;

    typedef logic [CTR_FIELD_W-1:0] ctr_t;

    // One BTB way. The tag field is the PC shifted down past index and byte
    // offset, so its upper bits are zero and still take part in the compare.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] tag;
        logic [ADDR_W-1:0] target;
        ctr_t              ctr;
    } btb_entry_t;

    // Weakly not-taken: reset value of every counter.
    function automatic ctr_t ctr_weak_nt(input int ctr_w);
        return ctr_t'((1 << (ctr_w - 1)) - 1);
    endfunction

    // Weakly taken: value given to a freshly allocated entry.
    function automatic ctr_t ctr_weak_t(input int ctr_w);
        return ctr_t'(1 << (ctr_w - 1));
    endfunction

    // Upper saturation limit.
    function automatic ctr_t ctr_max(input int ctr_w);
        return ctr_t'((1 << ctr_w) - 1);
    endfunction

    function automatic logic [ADDR_W-1:0] tag_of(input logic [ADDR_W-1:0] pc,
                                                  input int idx_w);
        return pc >> (idx_w + 2);
    endfunction

endpackage

// File: rtl/btb_sat_ctr.sv
// Saturating up/down direction counter used on the BTB update path.
module btb_sat_ctr
    import btb_pkg::*;
#(
    parameter int CTR_W = CTR_W_DEF
) (
    input  logic [CTR_FIELD_W-1:0] ctr,
    input  logic                   taken,
    output logic [CTR_FIELD_W-1:0] ctr_next
);

    localparam ctr_t CTR_TOP = ctr_max(CTR_W);

    // Step toward taken/not-taken, holding at 0 and at the top value.
    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr < CTR_TOP) begin
                ctr_next = ctr + ctr_t'(1);
            end
        end else if (ctr != '0) begin
            ctr_next = ctr - ctr_t'(1);
        end
    end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with direction counters. Looks up the
// fetch PC, predicts taken branches, checks the prediction one stage later
// against the decoded branch and issues flush/redirect to fetch.
module btb_assoc
    import btb_pkg::*;
#(
    parameter int SETS  = SETS_DEF,
    parameter int WAYS  = WAYS_DEF,
    parameter int CTR_W = CTR_W_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              STALL,
    input  logic [ADDR_W-1:0] IF_PC,
    input  logic [ADDR_W-1:0] ID_PC,
    input  logic              ID_IS_BRANCH,
    input  logic              ID_TAKEN,
    input  logic [ADDR_W-1:0] ID_TARGET,
    output logic              FLUSH,
    output logic              REDIRECT,
    output logic [ADDR_W-1:0] REDIRECT_PC,
    output logic [31:0]       BRANCH_CNT,
    output logic [31:0]       MISS_CNT
);

    localparam int   IDX_W     = $clog2(SETS);
    localparam int   WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam ctr_t CTR_RST   = ctr_weak_nt(CTR_W);
    localparam ctr_t CTR_ALLOC = ctr_weak_t(CTR_W);

    btb_entry_t        mem [SETS][WAYS];

    logic [IDX_W-1:0]  if_idx;
    logic [IDX_W-1:0]  id_idx;
    logic [ADDR_W-1:0] if_tag;
    logic [ADDR_W-1:0] id_tag;

    logic [2:0]        if_nmatch;
    logic [2:0]        id_nmatch;
    logic [WAY_W-1:0]  if_way;
    logic [WAY_W-1:0]  id_way;
    logic              if_hit;
    logic              id_hit;
    logic              take_if;
    logic [ADDR_W-1:0] hit_tgt;

    logic [WAY_W-1:0]  victim;
    logic [WAY_W-1:0]  alloc_way;
    logic              alloc_found;
    logic              do_update;
    logic              do_alloc;

    ctr_t              id_ctr;
    ctr_t              ctr_next;

    logic              pred_q;
    logic [ADDR_W-1:0] tgt_q;
    logic              mispred;

    // Byte-offset bits never select anything; they only ride along into tag_of.
    logic              unused_pc_lsb;
    assign unused_pc_lsb = ^{IF_PC[1:0], ID_PC[1:0]};

    assign if_idx = IF_PC[IDX_W+1:2];
    assign id_idx = ID_PC[IDX_W+1:2];
    assign if_tag = tag_of(IF_PC, IDX_W);
    assign id_tag = tag_of(ID_PC, IDX_W);

    // Fetch-side lookup: count matching ways; only a single match is a hit.
    always_comb begin
        if_nmatch = '0;
        if_way    = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (mem[if_idx][w].valid && (mem[if_idx][w].tag == if_tag)) begin
                if_nmatch = if_nmatch + 3'd1;
                if_way    = WAY_W'(w);
            end
        end
    end

    assign if_hit  = (if_nmatch == 3'd1);
    assign take_if = if_hit && mem[if_idx][if_way].ctr[CTR_W-1];
    assign hit_tgt = if_hit ? mem[if_idx][if_way].target : '0;

    // Decode-side lookup for the update path.
    always_comb begin
        id_nmatch = '0;
        id_way    = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (mem[id_idx][w].valid && (mem[id_idx][w].tag == id_tag)) begin
                id_nmatch = id_nmatch + 3'd1;
                id_way    = WAY_W'(w);
            end
        end
    end

    assign id_hit = (id_nmatch == 3'd1);
    assign id_ctr = mem[id_idx][id_way].ctr;

    // Allocation target: lowest invalid way, otherwise the set's victim pointer.
    always_comb begin
        alloc_way   = victim;
        alloc_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!alloc_found && !mem[id_idx][w].valid) begin
                alloc_way   = WAY_W'(w);
                alloc_found = 1'b1;
            end
        end
    end

    assign do_update = !STALL && ID_IS_BRANCH;
    assign do_alloc  = do_update && !id_hit && ID_TAKEN;

    assign mispred = ID_IS_BRANCH &&
                     ((pred_q != ID_TAKEN) ||
                      (ID_TAKEN && pred_q && (tgt_q != ID_TARGET)));

    btb_sat_ctr #(
        .CTR_W    (CTR_W)
    ) u_sat_ctr (
        .ctr      (id_ctr),
        .taken    (ID_TAKEN),
        .ctr_next (ctr_next)
    );

    // Entry array: train hit entries, allocate on taken misses.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    mem[s][w].valid  <= 1'b0;
                    mem[s][w].tag    <= '0;
                    mem[s][w].target <= '0;
                    mem[s][w].ctr    <= CTR_RST;
                end
            end
        end else if (do_update) begin
            if (id_hit) begin
                mem[id_idx][id_way].ctr <= ctr_next;
                if (ID_TAKEN) begin
                    mem[id_idx][id_way].target <= ID_TARGET;
                end
            end else if (ID_TAKEN) begin
                mem[id_idx][alloc_way].valid  <= 1'b1;
                mem[id_idx][alloc_way].tag    <= id_tag;
                mem[id_idx][alloc_way].target <= ID_TARGET;
                mem[id_idx][alloc_way].ctr    <= CTR_ALLOC;
            end
        end
    end

    generate
        if (WAYS > 1) begin : g_vptr
            logic [WAY_W-1:0] vptr [SETS];

            // Round-robin victim pointer, advanced on every allocation.
            always_ff @(posedge CLK or negedge RESET) begin
                if (!RESET) begin
                    for (int s = 0; s < SETS; s++) begin
                        vptr[s] <= '0;
                    end
                end else if (do_alloc) begin
                    vptr[id_idx] <= vptr[id_idx] + WAY_W'(1);
                end
            end

            assign victim = vptr[id_idx];
        end else begin : g_no_vptr
            assign victim = '0;
        end
    endgenerate

    // Prediction pipeline and fetch control; a squashed fetch carries no prediction.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pred_q      <= 1'b0;
            tgt_q       <= '0;
            FLUSH       <= 1'b0;
            REDIRECT    <= 1'b0;
            REDIRECT_PC <= '0;
        end else if (!STALL) begin
            pred_q   <= mispred ? 1'b0 : take_if;
            tgt_q    <= hit_tgt;
            FLUSH    <= mispred;
            REDIRECT <= mispred || take_if;
            if (mispred) begin
                REDIRECT_PC <= ID_TAKEN ? ID_TARGET : (ID_PC + 32'd8);
            end else begin
                REDIRECT_PC <= take_if ? hit_tgt : (IF_PC + 32'd4);
            end
        end
    end

    // Resolved-branch and misprediction statistics, wrapping.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            BRANCH_CNT <= '0;
            MISS_CNT   <= '0;
        end else if (!STALL) begin
            if (ID_IS_BRANCH) begin
                BRANCH_CNT <= BRANCH_CNT + 32'd1;
            end
            if (mispred) begin
                MISS_CNT <= MISS_CNT + 32'd1;
            end
        end
    end

endmodule

// File: doc/btb_assoc.md
BTB_ASSOC -- requirements
Module: btb_assoc

Interface
REQ-001 SHALL have parameter SETS, default 512, number of sets (power of 2, 2..4096).
REQ-002 SHALL have parameter WAYS, default 2, associativity (1, 2 or 4).
REQ-003 SHALL have parameter CTR_W, default 2, saturating direction-counter width (1..3).
REQ-004 SHALL have ports:
  CLK  in  1  clock, rising edge.
  RESET  in  1  asynchronous, active-low reset.
  STALL  in  1  freeze all state and outputs.
  IF_PC  in  32  fetch PC to look up.
  ID_PC  in  32  PC of the instruction in decode.
  ID_IS_BRANCH  in  1  decode instruction is a conditional branch.
  ID_TAKEN  in  1  resolved direction of the decode branch.
  ID_TARGET  in  32  resolved target of the decode branch.
  FLUSH  out  1  squash fetch/decode (registered).
  REDIRECT  out  1  fetch SHALL use REDIRECT_PC (registered).
  REDIRECT_PC  out  32  next fetch PC (registered).
  BRANCH_CNT  out  32  resolved-branch count.
  MISS_CNT  out  32  misprediction count.

Function
REQ-005 SHALL derive index = PC[IDX_W+1:2] and tag = PC[31:IDX_W+2], with IDX_W = log2(SETS).
REQ-006 SHALL store per way: valid, tag, 32-bit target and a CTR_W counter; per set, a log2(WAYS)-bit victim pointer (absent if WAYS=1).
REQ-007 SHALL declare an IF hit when exactly one valid way matches the tag; take_IF = hit AND the counter MSB of the hit way is 1.
REQ-008 SHALL, each non-stalled cycle, register pred_q = take_IF and tgt_q = hit target, describing the instruction entering ID next cycle.
REQ-009 SHALL compute mispred = ID_IS_BRANCH AND (pred_q != ID_TAKEN OR (ID_TAKEN AND pred_q AND tgt_q != ID_TARGET)).
REQ-010 SHALL, on a non-stalled edge, register FLUSH = mispred, REDIRECT = mispred OR take_IF, REDIRECT_PC = mispred ? (ID_TAKEN ? ID_TARGET : ID_PC+8) : (take_IF ? hit target : IF_PC+4).
REQ-011 SHALL clear pred_q instead of loading it when mispred is 1, because the fetched instruction is squashed.
REQ-012 SHALL update on a non-stalled edge when ID_IS_BRANCH=1, as follows: on ID hit, increment the counter if taken or decrement it if not, saturating at 0 and at 2^CTR_W-1; on a taken hit, also overwrite the target.
REQ-013 SHALL, on ID miss with ID_TAKEN=1, allocate the lowest-numbered invalid way, or else the way at the victim pointer, then advance the pointer modulo WAYS; new entry: valid=1, tag, ID_TARGET, counter = 2^(CTR_W-1) (weakly taken).
REQ-014 SHALL NOT allocate on ID miss with ID_TAKEN=0.
REQ-015 SHALL give read-before-write semantics: an IF lookup in the same cycle as an ID update to the same set or way sees pre-update contents.
REQ-016 SHALL increment BRANCH_CNT per non-stalled ID_IS_BRANCH cycle and MISS_CNT per non-stalled mispred cycle, both wrapping modulo 2^32.
REQ-017 SHALL hold every register (array, pointers, pred_q, outputs, statistics) while STALL=1; mispred is ignored while stalled.
REQ-018 SHALL make all state updates synchronous to CLK; no other signal is used as a clock.

Reset
REQ-019 SHALL, while RESET=0, clear all valid bits, set all counters to 2^(CTR_W-1)-1 (weakly not-taken) and all victim pointers to 0.
REQ-020 SHALL reset FLUSH=0, REDIRECT=0, REDIRECT_PC=0, BRANCH_CNT=0, MISS_CNT=0, pred_q=0, tgt_q=0.
REQ-021 SHALL abandon an in-flight update when reset is asserted mid-operation; the first post-reset lookup misses.

Structure
REQ-022 SHALL place ADDR_W=32, default SETS/WAYS/CTR_W, the counter init/saturation constants and the entry record typedef in shared package btb_pkg.
REQ-023 SHALL implement the counter update in sub-module btb_sat_ctr (inputs: ctr, taken; output: next ctr), instanced once for the update path.

Verification
REQ-024 SHALL cover cold miss: IF_PC=0x100 after reset -> REDIRECT=0, REDIRECT_PC=0x104.
REQ-025 SHALL cover allocate/predict: ID_PC=0x100, branch, taken, target 0x400 -> FLUSH=1, REDIRECT_PC=0x400; next IF_PC=0x100 -> REDIRECT=1, REDIRECT_PC=0x400.
REQ-026 SHALL cover saturation: CTR_W=2, four taken then one not-taken for 0x100 -> counter 3 then 2, prediction still taken; a second not-taken gives 1, not-taken prediction.
REQ-027 SHALL cover eviction: WAYS=2, taken branches at 0x100, 0x100+4*SETS and 0x100+8*SETS -> the third allocation replaces way 0; the first PC then misses.
REQ-028 SHALL cover not-taken mispredict: predicted-taken 0x200 resolves not-taken -> FLUSH=1, REDIRECT_PC=0x208, MISS_CNT+1.
REQ-029 SHALL cover stall plus mid-run reset: STALL=1 for 3 cycles during a mispredict holds all outputs and counters; RESET low for one cycle -> all outputs 0 and a subsequent IF_PC=0x400 misses.
